alarm_unit: RTL and testbench

ALARM_UNIT -- requirements
Module: alarm_unit

---
 rtl/alarm_pkg.sv | 30 +++
 rtl/blink_div.sv | 39 +++
 rtl/alarm_unit.sv | 167 ++++++++++++++++
 tb/tb_alarm_unit.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm unit: the controller state encoding,
// the edit_field encoding and the width of a minutes/seconds field.
// Ports: none (package).
package alarm_pkg;

  // Width of one time field (minutes or seconds, 0..59, six bits)
  localparam int TIME_W = 6;

  // Controller states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_EDIT_MIN = 3'd1,
    ST_EDIT_SEC = 3'd2,
    ST_ARMED    = 3'd3,
    ST_RINGING  = 3'd4
  } state_t;

  // Which alarm field the user is currently editing
  typedef enum logic [1:0] {
    FIELD_NONE = 2'd0,
    FIELD_MIN  = 2'd1,
    FIELD_SEC  = 2'd2
  } edit_field_t;

  // Step a minutes/seconds value, wrapping 59 back to 0
  function automatic logic [TIME_W-1:0] incWrap59(input logic [TIME_W-1:0] v);
    return (v >= TIME_W'(59)) ? '0 : v + TIME_W'(1);
  endfunction

endpackage

// File: rtl/blink_div.sv
// Clock divider for the alarm LED blink.
// Emits a one-cycle toggle request every DIV enabled cycles.
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous active-low reset
//   clr    - restart the divider from zero (takes priority over en)
//   en     - count this cycle
//   toggle - high for the cycle in which the LED should flip
module blink_div #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic toggle
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_count;

  // Free-running modulo-DIV counter, restarted whenever clr is seen so the
  // first half period after a restart is always a full DIV cycles long
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= (r_count == LAST) ? '0 : r_count + CW'(1);
    end
  end

  // Toggle request on the last count of each period
  assign toggle = en && !clr && (r_count == LAST);

endmodule

// File: rtl/alarm_unit.sv
// Alarm controller for the stopwatch: lets the user program an mm:ss alarm
// with three keys, arms it, and rings for a bounded number of seconds when
// the running time steps onto the alarm value.
// Ports:
//   clk, rst_n            - clock and asynchronous active-low reset
//   tick_1hz              - one-cycle pulse per second
//   cur_min, cur_sec      - current stopwatch time
//   key_set/inc/ack       - debounced one-cycle key pulses
//   alarm_min, alarm_sec  - programmed alarm time
//   edit_field            - 0 none, 1 minutes, 2 seconds
//   armed, ringing, led   - status outputs (all registered)
module alarm_unit
  import alarm_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int RING_SECONDS = 30
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_1hz,
  input  logic [TIME_W-1:0] cur_min,
  input  logic [TIME_W-1:0] cur_sec,
  input  logic              key_set,
  input  logic              key_inc,
  input  logic              key_ack,
  output logic [TIME_W-1:0] alarm_min,
  output logic [TIME_W-1:0] alarm_sec,
  output logic [1:0]        edit_field,
  output logic              armed,
  output logic              ringing,
  output logic              led
);

  // Quarter-second half period gives a 2 Hz blink; never let it reach zero
  localparam int BLINK_DIV = (CLK_HZ / 4 > 0) ? CLK_HZ / 4 : 1;
  localparam logic [5:0] RING_LOAD = 6'(RING_SECONDS);

  state_t              r_state, w_stateNext;
  logic [TIME_W-1:0]   r_alarmMin, w_alarmMinNext;
  logic [TIME_W-1:0]   r_alarmSec, w_alarmSecNext;
  logic [5:0]          r_ringCnt, w_ringCntNext;
  logic [2*TIME_W-1:0] r_prevTime;
  logic [1:0]          r_editField, w_editFieldNext;
  logic                r_armed, w_armedNext;
  logic                r_ringing, w_ringingNext;
  logic                r_led, w_ledNext;
  logic [2*TIME_W-1:0] w_curTime;
  logic                w_match;
  logic                w_ringEntry;
  logic                w_blinkEn;
  logic                w_blinkToggle;

  assign w_curTime = {cur_min, cur_sec};

  // Only the step onto the alarm time counts; a time that merely sits on
  // the alarm value (e.g. when arming) must not fire
  assign w_match = (w_curTime == {r_alarmMin, r_alarmSec}) && (w_curTime != r_prevTime);

  assign w_ringEntry = (r_state != ST_RINGING) && (w_stateNext == ST_RINGING);
  assign w_blinkEn   = (r_state == ST_RINGING);

  blink_div #(
    .DIV(BLINK_DIV)
  ) u_blinkDiv (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_ringEntry),
    .en    (w_blinkEn),
    .toggle(w_blinkToggle)
  );

  // State register plus every datapath register of the controller
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_alarmMin  <= '0;
      r_alarmSec  <= '0;
      r_ringCnt   <= '0;
      r_prevTime  <= '0;
      r_editField <= FIELD_NONE;
      r_armed     <= 1'b0;
      r_ringing   <= 1'b0;
      r_led       <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_alarmMin  <= w_alarmMinNext;
      r_alarmSec  <= w_alarmSecNext;
      r_ringCnt   <= w_ringCntNext;
      r_prevTime  <= w_curTime;
      r_editField <= w_editFieldNext;
      r_armed     <= w_armedNext;
      r_ringing   <= w_ringingNext;
      r_led       <= w_ledNext;
    end
  end

  // Next-state logic: key_ack beats key_set beats key_inc, and user keys
  // in ARMED take precedence over a simultaneous match
  always_comb begin
    w_stateNext    = r_state;
    w_alarmMinNext = r_alarmMin;
    w_alarmSecNext = r_alarmSec;
    w_ringCntNext  = r_ringCnt;
    case (r_state)
      ST_IDLE: begin
        if (!key_ack && key_set) w_stateNext = ST_EDIT_MIN;
      end
      ST_EDIT_MIN: begin
        if (key_ack)      w_stateNext = ST_IDLE;
        else if (key_set) w_stateNext = ST_EDIT_SEC;
        else if (key_inc) w_alarmMinNext = incWrap59(r_alarmMin);
      end
      ST_EDIT_SEC: begin
        if (key_ack)      w_stateNext = ST_IDLE;
        else if (key_set) w_stateNext = ST_ARMED;
        else if (key_inc) w_alarmSecNext = incWrap59(r_alarmSec);
      end
      ST_ARMED: begin
        if (key_ack)      w_stateNext = ST_IDLE;
        else if (key_set) w_stateNext = ST_EDIT_MIN;
        else if (w_match) begin
          w_stateNext   = ST_RINGING;
          w_ringCntNext = RING_LOAD;
        end
      end
      ST_RINGING: begin
        if (key_ack) begin
          w_stateNext = ST_ARMED;
        end else if (tick_1hz) begin
          if (r_ringCnt == 6'd1) w_stateNext = ST_ARMED;
          w_ringCntNext = r_ringCnt - 6'd1;
        end
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  // Registered status outputs follow the state being entered; the LED
  // starts lit on entry to RINGING and then flips on divider requests
  always_comb begin
    w_editFieldNext = FIELD_NONE;
    w_armedNext     = 1'b0;
    w_ringingNext   = 1'b0;
    w_ledNext       = 1'b0;
    case (w_stateNext)
      ST_EDIT_MIN: w_editFieldNext = FIELD_MIN;
      ST_EDIT_SEC: w_editFieldNext = FIELD_SEC;
      ST_ARMED:    w_armedNext = 1'b1;
      ST_RINGING: begin
        w_armedNext   = 1'b1;
        w_ringingNext = 1'b1;
        if (w_ringEntry)        w_ledNext = 1'b1;
        else if (w_blinkToggle) w_ledNext = ~r_led;
        else                    w_ledNext = r_led;
      end
      default: ;
    endcase
  end

  assign alarm_min  = r_alarmMin;
  assign alarm_sec  = r_alarmSec;
  assign edit_field = r_editField;
  assign armed      = r_armed;
  assign ringing    = r_ringing;
  assign led        = r_led;

endmodule

// File: tb/tb_alarm_unit.sv
// Self-checking bench for alarm_unit: directed scenarios followed by a
// randomized run, all compared cycle by cycle with a behavioural model.
module tb_alarm_unit;

  localparam int CLK_HZ       = 8;
  localparam int RING_SECONDS = 3;
  localparam int BLINK_HALF   = CLK_HZ / 4;

  localparam int M_IDLE     = 0;
  localparam int M_EDIT_MIN = 1;
  localparam int M_EDIT_SEC = 2;
  localparam int M_ARMED    = 3;
  localparam int M_RINGING  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick1hz = 1'b0;
  logic       keySet = 1'b0;
  logic       keyInc = 1'b0;
  logic       keyAck = 1'b0;
  logic [5:0] curMin = '0;
  logic [5:0] curSec = '0;
  logic [5:0] alarmMin;
  logic [5:0] alarmSec;
  logic [1:0] editField;
  logic       armed;
  logic       ringing;
  logic       led;

  int passCount = 0;
  int checkCount = 0;

  // Behavioural model state
  int mMode;
  int mAlmMin, mAlmSec;
  int mPrevMin, mPrevSec;
  int mTicksSeen;
  int mRingAge;

  alarm_unit #(
    .CLK_HZ(CLK_HZ),
    .RING_SECONDS(RING_SECONDS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick_1hz  (tick1hz),
    .cur_min   (curMin),
    .cur_sec   (curSec),
    .key_set   (keySet),
    .key_inc   (keyInc),
    .key_ack   (keyAck),
    .alarm_min (alarmMin),
    .alarm_sec (alarmSec),
    .edit_field(editField),
    .armed     (armed),
    .ringing   (ringing),
    .led       (led)
  );

  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  task automatic modelReset();
    mMode = M_IDLE;
    mAlmMin = 0;
    mAlmSec = 0;
    mPrevMin = 0;
    mPrevSec = 0;
    mTicksSeen = 0;
    mRingAge = 0;
  endtask

  // One rising edge of the alarm rules, using the inputs currently driven
  task automatic modelStep();
    bit match;
    match = (int'(curMin) == mAlmMin) && (int'(curSec) == mAlmSec) &&
            !((int'(curMin) == mPrevMin) && (int'(curSec) == mPrevSec));
    case (mMode)
      M_IDLE: if (!keyAck && keySet) mMode = M_EDIT_MIN;
      M_EDIT_MIN: begin
        if (keyAck)      mMode = M_IDLE;
        else if (keySet) mMode = M_EDIT_SEC;
        else if (keyInc) mAlmMin = (mAlmMin + 1) % 60;
      end
      M_EDIT_SEC: begin
        if (keyAck)      mMode = M_IDLE;
        else if (keySet) mMode = M_ARMED;
        else if (keyInc) mAlmSec = (mAlmSec + 1) % 60;
      end
      M_ARMED: begin
        if (keyAck)      mMode = M_IDLE;
        else if (keySet) mMode = M_EDIT_MIN;
        else if (match) begin
          mMode = M_RINGING;
          mTicksSeen = 0;
          mRingAge = 0;
        end
      end
      default: begin
        if (keyAck) begin
          mMode = M_ARMED;
        end else begin
          mRingAge++;
          if (tick1hz) begin
            mTicksSeen++;
            if (mTicksSeen == RING_SECONDS) mMode = M_ARMED;
          end
        end
      end
    endcase
    mPrevMin = int'(curMin);
    mPrevSec = int'(curSec);
  endtask

  task automatic checkAll(input string phase);
    int expField;
    int expLed;
    expField = (mMode == M_EDIT_MIN) ? 1 : (mMode == M_EDIT_SEC) ? 2 : 0;
    expLed = ((mMode == M_RINGING) && (((mRingAge / BLINK_HALF) % 2) == 0)) ? 1 : 0;
    checkOutput({phase, "/alarmMin"}, int'(alarmMin), mAlmMin);
    checkOutput({phase, "/alarmSec"}, int'(alarmSec), mAlmSec);
    checkOutput({phase, "/editField"}, int'(editField), expField);
    checkOutput({phase, "/armed"}, int'(armed), (mMode == M_ARMED || mMode == M_RINGING) ? 1 : 0);
    checkOutput({phase, "/ringing"}, int'(ringing), (mMode == M_RINGING) ? 1 : 0);
    checkOutput({phase, "/led"}, int'(led), expLed);
  endtask

  // Drive one cycle of inputs, clock it, then compare against the model
  task automatic applyStimulus(input bit s, input bit i, input bit a, input bit t,
                               input int cm, input int cs, input string phase);
    keySet = s;
    keyInc = i;
    keyAck = a;
    tick1hz = t;
    curMin = 6'(cm);
    curSec = 6'(cs);
    @(posedge clk);
    modelStep();
    #1;
    checkAll(phase);
    @(negedge clk);
    keySet = 1'b0;
    keyInc = 1'b0;
    keyAck = 1'b0;
    tick1hz = 1'b0;
  endtask

  task automatic idleCycles(input int n, input string phase);
    for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 0, int'(curMin), int'(curSec), phase);
  endtask

  task automatic pressKey(input bit s, input bit i, input bit a, input string phase);
    applyStimulus(s, i, a, 0, int'(curMin), int'(curSec), phase);
  endtask

  // Asynchronous reset mid clock-low phase; outputs must clear with no edge
  task automatic doReset(input string phase);
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkAll(phase);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic programAlarm(input int mins, input int secs, input string phase);
    pressKey(1, 0, 0, phase);
    for (int k = 0; k < mins; k++) pressKey(0, 1, 0, phase);
    pressKey(1, 0, 0, phase);
    for (int k = 0; k < secs; k++) pressKey(0, 1, 0, phase);
    pressKey(1, 0, 0, phase);
  endtask

  initial begin
    modelReset();
    #1;
    checkAll("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Setup with a seconds wrap: 118 increments take seconds 0 -> 59 -> 0 -> 58
    pressKey(1, 0, 0, "setup");
    checkOutput("setupField1", int'(editField), 1);
    pressKey(0, 1, 0, "setup");
    pressKey(0, 1, 0, "setup");
    pressKey(1, 0, 0, "setup");
    checkOutput("setupField2", int'(editField), 2);
    for (int k = 0; k < 59; k++) pressKey(0, 1, 0, "setup");
    checkOutput("setupSec59", int'(alarmSec), 59);
    pressKey(0, 1, 0, "setup");
    checkOutput("setupSecWrap", int'(alarmSec), 0);
    for (int k = 0; k < 58; k++) pressKey(0, 1, 0, "setup");
    pressKey(1, 0, 0, "setup");
    checkOutput("setupField0", int'(editField), 0);
    checkOutput("setupArmed", int'(armed), 1);
    checkOutput("setupMin", int'(alarmMin), 2);
    checkOutput("setupSec", int'(alarmSec), 58);

    // Trigger at 00:05 and ring out over three ticks
    doReset("rstSetup");
    programAlarm(0, 5, "trigArm");
    applyStimulus(0, 0, 0, 0, 0, 4, "trig");
    checkOutput("trigNotYet", int'(ringing), 0);
    applyStimulus(0, 0, 0, 0, 0, 5, "trig");
    checkOutput("trigRinging", int'(ringing), 1);
    checkOutput("trigLedOn", int'(led), 1);
    applyStimulus(0, 0, 0, 0, 0, 5, "trig");
    checkOutput("trigLedHold", int'(led), 1);
    applyStimulus(0, 0, 0, 0, 0, 5, "trig");
    checkOutput("trigLedOff", int'(led), 0);
    for (int n = 0; n < RING_SECONDS; n++) begin
      idleCycles(2, "trigRing");
      checkOutput("trigStillRinging", int'(ringing), 1);
      applyStimulus(0, 0, 0, 1, 0, 5, "trigTick");
    end
    checkOutput("trigDoneRinging", int'(ringing), 0);
    checkOutput("trigDoneArmed", int'(armed), 1);
    checkOutput("trigDoneLed", int'(led), 0);

    // Silence with key_ack, then re-trigger on a fresh entry into match
    applyStimulus(0, 0, 0, 0, 0, 4, "sil");
    applyStimulus(0, 0, 0, 0, 0, 5, "sil");
    checkOutput("silRinging", int'(ringing), 1);
    pressKey(0, 0, 1, "sil");
    checkOutput("silRingOff", int'(ringing), 0);
    checkOutput("silLedOff", int'(led), 0);
    checkOutput("silArmed", int'(armed), 1);
    applyStimulus(0, 0, 0, 0, 0, 4, "sil");
    applyStimulus(0, 0, 0, 0, 0, 5, "sil");
    checkOutput("silRetrigger", int'(ringing), 1);

    // Reset while ringing
    idleCycles(1, "rstRing");
    doReset("rstRing");
    checkOutput("rstRingRinging", int'(ringing), 0);
    checkOutput("rstRingArmed", int'(armed), 0);
    checkOutput("rstRingLed", int'(led), 0);
    checkOutput("rstRingAlarmSec", int'(alarmSec), 0);

    // Arming while time already equals the alarm must not ring
    applyStimulus(0, 0, 0, 0, 0, 10, "noFalse");
    programAlarm(0, 10, "noFalse");
    idleCycles(6, "noFalse");
    checkOutput("noFalseRinging", int'(ringing), 0);
    checkOutput("noFalseArmed", int'(armed), 1);
    applyStimulus(0, 0, 0, 0, 0, 9, "noFalse");
    applyStimulus(0, 0, 0, 0, 0, 10, "noFalse");
    checkOutput("laterEntryRings", int'(ringing), 1);
    pressKey(0, 0, 1, "noFalse");

    // Key priority
    pressKey(1, 0, 1, "prio");
    checkOutput("prioAckSetArmed", int'(armed), 0);
    checkOutput("prioAckSetField", int'(editField), 0);
    pressKey(1, 0, 0, "prio");
    pressKey(1, 1, 0, "prio");
    checkOutput("prioSetIncField", int'(editField), 2);
    checkOutput("prioSetIncMin", int'(alarmMin), 0);
    pressKey(0, 0, 1, "prio");

    // Randomized run
    for (int c = 0; c < 800; c++) begin
      bit s, i, a, t;
      int cm, cs, pick;
      if (c == 400) doReset("rndReset");
      t = ($urandom_range(0, 4) == 0);
      cm = int'(curMin);
      cs = int'(curSec);
      s = 0;
      i = 0;
      a = 0;
      if ($urandom_range(0, 2) == 0) begin
        pick = $urandom_range(0, 3);
        if (pick <= 1) begin
          cm = mAlmMin;
          cs = mAlmSec;
        end else if (pick == 2) begin
          cm = mAlmMin;
          cs = (mAlmSec + 1) % 64;
        end else begin
          cm = $urandom_range(0, 63);
          cs = $urandom_range(0, 63);
        end
      end else begin
        s = ($urandom_range(0, 7) == 0);
        i = ($urandom_range(0, 3) == 0);
        a = ($urandom_range(0, 9) == 0);
      end
      applyStimulus(s, i, a, t, cm, cs, "rnd");
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
